uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART RX path. It detects the start edge, drives the oversampling data sampler through the enable and edge-count interface, and steps through start, data, parity and stop bits. It assembles the byte from the sampler's majority-voted bit and issues a one-cycle valid pulse, or an error pulse when a check fails. It sits between RX_IN and the RX-to-system synchronizer.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_edge_bit_cnt.sv | 62 ++++++
 rtl/uart_rx_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART RX controller slice.
//   rx_state_e     : receive sequencer state encoding
//   PS_8/16/32     : supported oversampling ratios
//   DATA_WIDTH_DEF : default number of data bits per frame
//   ps_supported() : true when a prescale value is one of the supported ratios
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned PS_8           = 8;
    localparam int unsigned PS_16          = 16;
    localparam int unsigned PS_32          = 32;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    function automatic logic ps_supported(input logic [31:0] ps);
        return (ps == PS_8) || (ps == PS_16) || (ps == PS_32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// ---------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
// Oversampling edge counter and frame bit counter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en_i         : count while high; edge counter held at 0 while low
//   bit_clr_i    : hold the bit counter at 0
//   prescale_i   : latched oversampling ratio
//   edge_cnt_o   : edge index within the current bit, 0..prescale_i-1
//   bit_cnt_o    : number of bit ends seen since the last clear
//   bit_end_o    : high on the last edge of the current bit
// ---------------------------------------------------------------------------
module uart_rx_edge_bit_cnt #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  bit_clr_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [PRESCALE_W-1:0] edge_cnt_o,
    output logic [BIT_CNT_W-1:0]  bit_cnt_o,
    output logic                  bit_end_o
);

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic                  bit_end;

    assign bit_end = en_i && (edge_q == (prescale_i - PRESCALE_W'(1)));

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (!en_i) begin
            edge_d = '0;
            bit_d  = '0;
        end else begin
            edge_d = bit_end ? '0 : edge_q + PRESCALE_W'(1);
            if (bit_clr_i) begin
                bit_d = '0;
            end else if (bit_end) begin
                bit_d = bit_q + BIT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;
    assign bit_end_o  = bit_end;

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// UART receive sequencer: detects the start edge, drives the oversampling
// data sampler, steps through start/data/parity/stop bits, assembles the
// byte from the sampler's voted bit and pulses data_valid or an error flag.
//   CLK, RST    : oversampling clock, asynchronous active-low reset
//   RX_IN       : serial line (idle high), only looked at in IDLE
//   prescale    : oversampling ratio (8, 16 or 32), latched at frame start
//   PAR_EN      : parity bit present; PAR_TYP : 0 even, 1 odd
//   sampled_bit : majority-voted bit from the sampler
//   dat_samp_en : sampler enable; edge_cnt : edge index within the bit
//   P_DATA      : received byte, updated only with data_valid
//   data_valid, par_err, stp_err : one-cycle result pulses
//   err_cnt     : saturating frame error count
// Build option: define UART_RX_ERR_CNT_EN to build the err_cnt counter;
// otherwise err_cnt is tied to 0.
// ---------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic [7:0]            err_cnt
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    rx_state_e             state_q;
    logic [PRESCALE_W-1:0] ps_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_flag_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  samp_en_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;

    logic                  cnt_en;
    logic                  bit_clr;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  bit_end;
    logic                  par_exp;

    assign cnt_en  = (state_q != ST_IDLE);
    // Bit counter sits at 0 through the start bit so DATA begins at index 0.
    assign bit_clr = (state_q == ST_START);
    assign par_exp = par_typ_q ? ~^shift_q : ^shift_q;

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_edge_bit_cnt (
        .clk        (CLK),
        .rst_n      (RST),
        .en_i       (cnt_en),
        .bit_clr_i  (bit_clr),
        .prescale_i (ps_q),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .bit_end_o  (bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            ps_q         <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_flag_q   <= 1'b0;
            shift_q      <= '0;
            p_data_q     <= '0;
            samp_en_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!RX_IN && ps_supported(32'(prescale))) begin
                        state_q    <= ST_START;
                        ps_q       <= prescale;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_flag_q <= 1'b0;
                        samp_en_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        if (!sampled_bit) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q   <= ST_IDLE;
                            samp_en_q <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                            if (bit_cnt == BIT_CNT_W'(i)) begin
                                shift_q[i] <= sampled_bit;
                            end
                        end
                        if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        par_flag_q <= (sampled_bit != par_exp);
                        state_q    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state_q   <= ST_IDLE;
                        samp_en_q <= 1'b0;
                        par_err_q <= par_flag_q;
                        stp_err_q <= ~sampled_bit;
                        if (!par_flag_q && sampled_bit) begin
                            data_valid_q <= 1'b1;
                            p_data_q     <= shift_q;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    samp_en_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       frame_err;

    // Counted on the same edge that raises par_err/stp_err, once per frame.
    assign frame_err = (state_q == ST_STOP) && bit_end && (par_flag_q || !sampled_bit);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt_q <= '0;
        end else if (frame_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign dat_samp_en = samp_en_q;
    assign P_DATA      = p_data_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed frames driven on RX_IN with a small mid-bit sampler model feeding
// sampled_bit. Each frame pushes its expected result into a queue; a monitor
// pops and compares whenever the DUT pulses data_valid, par_err or stp_err.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic [7:0] err_cnt;

    uart_rx_ctrl #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .prescale    (prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .err_cnt     (err_cnt)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Sampler model: capture RX_IN at the middle of each bit.
    always @(posedge CLK) begin
        if (dat_samp_en && (edge_cnt == (prescale >> 1)))
            sampled_bit <= RX_IN;
    end

    typedef struct {
        logic       v;
        logic       pe;
        logic       se;
        logic [7:0] data;
        logic [7:0] ec;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic [7:0] model_pdata = 8'h00;
    logic [7:0] model_ec = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // par_bad and stop_bit are hand-derived per vector by the caller.
    task automatic expect_frame(input logic [7:0] b, input logic par_bad,
                                input logic stop_bit, input int cyc_exp);
        exp_t e;
        e.v  = !par_bad && stop_bit;
        e.pe = par_bad;
        e.se = !stop_bit;
        if (e.v) model_pdata = b;
        e.data = model_pdata;
`ifdef UART_RX_ERR_CNT_EN
        if ((e.pe || e.se) && model_ec != 8'hFF) model_ec = model_ec + 8'd1;
`endif
        e.ec  = model_ec;
        e.cyc = cyc_exp;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (RST && (data_valid || par_err || stp_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, data_valid, par_err, stp_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_valid", 32'(data_valid), 32'(e.v));
                chk("par_err", 32'(par_err), 32'(e.pe));
                chk("stp_err", 32'(stp_err), 32'(e.se));
                chk("P_DATA", 32'(P_DATA), 32'(e.data));
                chk("err_cnt", 32'(err_cnt), 32'(e.ec));
                if (e.cyc >= 0) chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int ps,
                              input logic par_en, input logic par_bit, input logic stop_bit);
        RX_IN = 1'b0;
        wait_cyc(ps);
        for (int i = 0; i < 8; i++) begin
            RX_IN = b[i];
            wait_cyc(ps);
        end
        if (par_en) begin
            RX_IN = par_bit;
            wait_cyc(ps);
        end
        RX_IN = stop_bit;
        wait_cyc(ps);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        wait_cyc(n);
    endtask

    task automatic cfg(input int ps, input logic pen, input logic ptyp);
        prescale = 6'(ps);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        RX_IN = 1'b1;
        model_pdata = 8'h00;
        model_ec = 8'h00;
        wait_cyc(3);
        RST = 1'b1;
        wait_cyc(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        RST = 1'b0;
        wait_cyc(3);
        chk("rst_dat_samp_en", 32'(dat_samp_en), 32'd0);
        chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        chk("rst_P_DATA", 32'(P_DATA), 32'd0);
        chk("rst_pulses", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        RST = 1'b1;
        wait_cyc(2);

        // 1: prescale 8, no parity, 0xA5, result 81 cycles after the start edge
        cfg(8, 1'b0, 1'b0);
        t0 = cyc;
        expect_frame(8'hA5, 1'b0, 1'b1, t0 + 81);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        idle(4);
        chk("t1_P_DATA", 32'(P_DATA), 32'h0000_00A5);

        // 2: prescale 16, even parity, 0x3C has four ones -> parity bit must be 0
        cfg(16, 1'b1, 1'b0);
        expect_frame(8'h3C, 1'b1, 1'b1, -1);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
        idle(4);
        chk("t2_P_DATA_held", 32'(P_DATA), 32'h0000_00A5);
        expect_frame(8'h3C, 1'b0, 1'b1, -1);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
        idle(4);
        chk("t2_P_DATA", 32'(P_DATA), 32'h0000_003C);

        // 3: start glitch at prescale 8 -> back to IDLE, no pulses
        cfg(8, 1'b0, 1'b0);
        RX_IN = 1'b0;
        wait_cyc(3);
        RX_IN = 1'b1;
        wait_cyc(5);
        @(negedge CLK);
        chk("t3_samp_en_bit_end", 32'(dat_samp_en), 32'd1);
        chk("t3_edge_cnt_bit_end", 32'(edge_cnt), 32'd7);
        @(posedge CLK);
        @(negedge CLK);
        chk("t3_samp_en_dropped", 32'(dat_samp_en), 32'd0);
        chk("t3_edge_cnt_idle", 32'(edge_cnt), 32'd0);
        idle(20);

        // 4: stop-bit errors; error counter from 0 to saturation
        do_reset();
        cfg(32, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b0, 1'b0, -1);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0);
        idle(4);
`ifdef UART_RX_ERR_CNT_EN
        chk("t4_err_cnt_1", 32'(err_cnt), 32'd1);
`else
        chk("t4_err_cnt_1", 32'(err_cnt), 32'd0);
`endif
        // Remaining 259 error frames at prescale 8 to keep the run short.
        cfg(8, 1'b0, 1'b0);
        for (int n = 0; n < 259; n++) begin
            expect_frame(8'hFF, 1'b0, 1'b0, -1);
            send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0);
            idle(4);
        end
`ifdef UART_RX_ERR_CNT_EN
        chk("t4_err_cnt_sat", 32'(err_cnt), 32'd255);
`else
        chk("t4_err_cnt_sat", 32'(err_cnt), 32'd0);
`endif
        chk("t4_P_DATA", 32'(P_DATA), 32'd0);

        // 5: back-to-back frames at prescale 32
        cfg(32, 1'b0, 1'b0);
        expect_frame(8'h12, 1'b0, 1'b1, -1);
        expect_frame(8'h34, 1'b0, 1'b1, -1);
        send_frame(8'h12, 32, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 32, 1'b0, 1'b0, 1'b1);
        idle(6);
        chk("t5_P_DATA", 32'(P_DATA), 32'h0000_0034);

        // 6: reset during data bit 4, then a clean frame
        cfg(8, 1'b0, 1'b0);
        RX_IN = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 4; i++) begin
            RX_IN = i[0];
            wait_cyc(8);
        end
        RX_IN = 1'b1;
        wait_cyc(4);
        chk("t6_mid_samp_en", 32'(dat_samp_en), 32'd1);
        chk("t6_mid_edge_cnt", 32'(edge_cnt), 32'd3);
        RST = 1'b0;
        #1;
        chk("t6_rst_samp_en", 32'(dat_samp_en), 32'd0);
        chk("t6_rst_edge_cnt", 32'(edge_cnt), 32'd0);
        chk("t6_rst_P_DATA", 32'(P_DATA), 32'd0);
        chk("t6_rst_pulses", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        chk("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
        model_pdata = 8'h00;
        model_ec = 8'h00;
        wait_cyc(3);
        RST = 1'b1;
        idle(3);
        expect_frame(8'h81, 1'b0, 1'b1, -1);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        idle(6);
        chk("t6_P_DATA", 32'(P_DATA), 32'h0000_0081);

        idle(10);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
